fp_to_int_seq: RTL and testbench
================================

# fp_to_int_seq

Sequential IEEE-754 single-precision to signed 32-bit integer converter that truncates toward zero, like a C cast. It sits directly downstream of the integer/float conversion stage and consumes the 32-bit float words that stage produces. Conversion uses one right-shift per cycle, driven by a small FSM with a start/done handshake. It saturates on overflow and flags NaN.

## Interface
- No parameters; the widths are fixed at 32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe. Sampled only in IDLE.
- fp_in  input  32  IEEE-754 single operand. Sampled on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse: the result is valid.
- int_out  output  32  two's-complement result. Held until the next completion.
- overflow  output  1  |value| does not fit in int32, or the operand is ±Inf. Valid with done, then held.
- invalid  output  1  the operand is NaN. Valid with done, then held.

## Operation
- Decode fp_in: s = bit 31, e = bits 30:23, f = bits 22:0.
- FSM states: IDLE and SHIFT.
- IDLE, start=1 → SHIFT. The edge also loads:
  - the sign register with s;
  - mag = {1'b1, f, 8'b0};
  - cnt = 158 − e (a 5-bit value, 0..31).
- Special loads override the normal load in IDLE. Each forces cnt = 0:
  - e < 127, including zero and denormals: mag = 0, flags 0. Result is 0.
  - e = 255 and f ≠ 0 (NaN): invalid = 1 and overflow = 0. Result 0x80000000.
  - e = 255 and f = 0 (±Inf): overflow = 1. Result is saturated.
  - e > 158, or e = 158 with anything other than s = 1 and f = 0: overflow = 1. Result is saturated.
  - Saturation value: 0x7FFFFFFF when s = 0, 0x80000000 when s = 1.
  - e = 158, s = 1, f = 0 (exactly −2^31): not an overflow. The normal path gives 0x80000000.
- SHIFT with cnt ≠ 0: mag ← mag >> 1 (logical) and cnt ← cnt − 1.
- SHIFT with cnt = 0:
  - int_out ← saturated or NaN value if flagged; else s ? −mag : mag (32-bit two's complement);
  - overflow and invalid are registered;
  - done ← 1 for this cycle only;
  - next state IDLE.
- No rounding. The fraction bits shifted out are discarded.
- start during SHIFT is ignored, with no queueing.
- start in the cycle where done is high is accepted, because the FSM is already in IDLE.

## Timing
- Reset, asynchronous:
  - state = IDLE;
  - busy, done, overflow, invalid = 0;
  - int_out = 0x00000000;
  - mag, cnt and the sign register cleared.
- Reset mid-conversion aborts it. No done pulse is issued for the aborted operation.
- busy = (state == SHIFT). It goes high the cycle after start is accepted.
- Let N be the shift count: 158 − e on the normal path, 0 for special loads.
- done is high in the cycle starting N+1 edges after the accepting edge. busy is low in that cycle.
- Examples:
  - Worst case, e = 127: done 32 cycles after start.
  - Special cases: done 1 cycle after start.
- Back-to-back throughput is one conversion per N+1 cycles.

## Test plan
- Reset is asserted asynchronously mid-cycle → all outputs are 0 immediately. Release, then start with 0x3F800000 (1.0) → done exactly 32 cycles after start, int_out = 0x00000001, flags 0.
- fp_in = 0xBF400000 (−0.75) → done 1 cycle after start, int_out = 0x00000000, flags 0.
- 0xC0200000 (−2.5) → int_out = 0xFFFFFFFE after 31 cycles. 0x4B000001 → int_out = 0x00800001 after 9 cycles.
- 0xCF000000 → int_out = 0x80000000, overflow = 0. 0x4F000000 → int_out = 0x7FFFFFFF, overflow = 1. 0xFF800000 → int_out = 0x80000000, overflow = 1.
- 0x7FC00000 (NaN) → int_out = 0x80000000, invalid = 1, overflow = 0.
- start is pulsed during SHIFT with another operand → it is ignored, and the first result is unchanged.
- start is held high through a done cycle → a second conversion begins, with busy high on the next cycle.
- rst_n is dropped for 1 cycle mid-SHIFT → no done pulse, and the FSM returns to IDLE.

Source files
------------

// File: rtl/fp_to_int_seq.sv
// IEEE-754 single to int32 converter, truncating toward zero like a C cast.
// One logical right shift per cycle; saturates on overflow/Inf, flags NaN.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// STATE_IDLE  | waiting for start; last result/flags held on the outputs
// STATE_SHIFT | shifting mag right until cnt reaches zero, then publishing
module fp_to_int_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] fp_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] int_out,
  output logic        overflow,
  output logic        invalid
);

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_SHIFT = 1'b1;

  logic        state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sat_q, sat_d;
  logic        nan_q, nan_d;
  logic [31:0] int_out_q, int_out_d;
  logic        overflow_q, overflow_d;
  logic        invalid_q, invalid_d;
  logic        done_q, done_d;

  logic        op_sign;
  logic [7:0]  op_exp;
  logic [22:0] op_frac;
  logic        op_small;
  logic        op_nan;
  logic        op_ovf;
  logic [31:0] result_w;

  assign op_sign  = fp_in[31];
  assign op_exp   = fp_in[30:23];
  assign op_frac  = fp_in[22:0];
  assign op_small = (op_exp < 8'd127);
  assign op_nan   = (op_exp == 8'd255) && (op_frac != 23'd0);
  // Inf falls under e > 158; exactly -2^31 is the only representable e = 158
  assign op_ovf   = (op_exp > 8'd158) ||
                    ((op_exp == 8'd158) && !(op_sign && (op_frac == 23'd0)));

  always_comb begin
    if (nan_q) begin
      result_w = 32'h8000_0000;
    end else if (sat_q) begin
      result_w = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      result_w = sign_q ? (~mag_q + 32'd1) : mag_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    nan_d      = nan_q;
    int_out_d  = int_out_q;
    overflow_d = overflow_q;
    invalid_d  = invalid_q;
    done_d     = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        if (start) begin
          state_d = STATE_SHIFT;
          sign_d  = op_sign;
          mag_d   = {1'b1, op_frac, 8'b0};
          // 158 - e modulo 32 only needs the low five exponent bits
          cnt_d   = 5'd30 - op_exp[4:0];
          sat_d   = 1'b0;
          nan_d   = 1'b0;
          if (op_small) begin
            mag_d = 32'd0;
            cnt_d = 5'd0;
          end else if (op_nan) begin
            nan_d = 1'b1;
            cnt_d = 5'd0;
          end else if (op_ovf) begin
            sat_d = 1'b1;
            cnt_d = 5'd0;
          end
        end
      end
      STATE_SHIFT: begin
        if (cnt_q != 5'd0) begin
          mag_d = mag_q >> 1;
          cnt_d = cnt_q - 5'd1;
        end else begin
          int_out_d  = result_w;
          overflow_d = sat_q;
          invalid_d  = nan_q;
          done_d     = 1'b1;
          state_d    = STATE_IDLE;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= STATE_IDLE;
      sign_q     <= 1'b0;
      mag_q      <= 32'd0;
      cnt_q      <= 5'd0;
      sat_q      <= 1'b0;
      nan_q      <= 1'b0;
      int_out_q  <= 32'd0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      nan_q      <= nan_d;
      int_out_q  <= int_out_d;
      overflow_q <= overflow_d;
      invalid_q  <= invalid_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == STATE_SHIFT);
  assign done     = done_q;
  assign int_out  = int_out_q;
  assign overflow = overflow_q;
  assign invalid  = invalid_q;

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Directed-vector bench for fp_to_int_seq: hand-computed results, latencies,
// handshake corner cases and asynchronous reset behaviour.
module tb_fp_to_int_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] fp_in;
  logic        busy;
  logic        done;
  logic [31:0] int_out;
  logic        overflow;
  logic        invalid;

  int vectors;
  int miscompares;

  fp_to_int_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .fp_in    (fp_in),
    .busy     (busy),
    .done     (done),
    .int_out  (int_out),
    .overflow (overflow),
    .invalid  (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts edges after the current point until done is seen; 99 means timeout.
  task automatic wait_done(output int lat);
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [31:0] fp, input logic [31:0] exp_int,
                     input logic exp_ovf, input logic exp_inv, input int exp_lat);
    int lat;
    @(negedge clk);
    start = 1'b1;
    fp_in = fp;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_int"}, int_out, exp_int);
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_inv"}, 32'(invalid), 32'(exp_inv));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int done_seen;
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    fp_in = 32'd0;
    #12 rst_n = 1'b1;

    // leave non-zero outputs behind so the async reset has something to clear
    run("pre_big", 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_int", int_out, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_inv", 32'(invalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("one",      32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 32);
    run("neg_0p75", 32'hBF40_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
    run("neg_2p5",  32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 31);
    run("2p23p1",   32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 9);
    run("min_int",  32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1);
    run("pos_2p31", 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    run("pos_2p32", 32'h4F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    run("neg_inf",  32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1);
    run("nan",      32'h7FC0_0000, 32'h8000_0000, 1'b0, 1'b1, 1);
    run("neg_one",  32'hBF80_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32);
    run("zero",     32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1);

    // start pulsed mid-SHIFT is ignored; done still lands on edge 32
    @(negedge clk);
    start = 1'b1;
    fp_in = 32'h3F80_0000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    fp_in = 32'h4F00_0000;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("ign_lat", 32'(lat), 32'd27);
    chk("ign_int", int_out, 32'h0000_0001);
    chk("ign_ovf", 32'(overflow), 32'd0);

    // start held through done starts the next conversion immediately
    @(negedge clk);
    start = 1'b1;
    fp_in = 32'h4B00_0001;
    @(posedge clk);
    #1;
    wait_done(lat);
    chk("hold_lat1", 32'(lat), 32'd9);
    @(posedge clk);
    #1;
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_done_low", 32'(done), 32'd0);
    start = 1'b0;
    wait_done(lat);
    chk("hold_lat2", 32'(lat), 32'd9);
    chk("hold_int", int_out, 32'h0080_0001);

    // reset for one cycle mid-SHIFT aborts without a done pulse
    @(negedge clk);
    start = 1'b1;
    fp_in = 32'h3F80_0000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_int", int_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    run("recover", 32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 31);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
